// File: rtl/step_profile_sequencer.sv
// Plays a programmed per-second step-rate profile and predicts the result the
// pedometer speed checker should report for it (threshold, window and cap).
module step_profile_sequencer #(
  parameter int SLOTS    = 16,
  parameter int RATE_W   = 9,
  parameter int THRESH   = 33,
  parameter int WINDOW   = 10,
  parameter int MAX_PASS = 9,
  parameter int TOTAL_W  = 16,
  localparam int ADDR_W  = $clog2(SLOTS),
  localparam int SEC_W   = $clog2(WINDOW + 1)
) (
  input  logic                secondClk,
  input  logic                reset,
  input  logic                start,
  input  logic                loop,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [RATE_W-1:0]   wr_data,
  output logic [RATE_W-1:0]   rate,
  output logic                rate_valid,
  output logic [ADDR_W-1:0]   slot,
  output logic                busy,
  output logic                done,
  output logic [15:0]         expected_pass,
  output logic [TOTAL_W-1:0]  total_steps
);

  localparam logic [RATE_W-1:0] THRESH_R  = RATE_W'(THRESH);
  localparam logic [SEC_W-1:0]  WINDOW_S  = SEC_W'(WINDOW);
  localparam logic [15:0]       MAX_P     = 16'(MAX_PASS);
  localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(SLOTS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   slot_q, slot_d;
  logic [RATE_W-1:0]   rate_q, rate_d;
  logic                rate_valid_q, rate_valid_d;
  logic [15:0]         pass_q, pass_d;
  logic [TOTAL_W-1:0]  total_q, total_d;
  logic [SEC_W-1:0]    sec_cnt_q, sec_cnt_d;
  logic [RATE_W-1:0]   mem_q [SLOTS];
  logic [RATE_W-1:0]   mem_d [SLOTS];
  logic [ADDR_W-1:0]   slot_nxt;

  // Running sum clamps at all-ones instead of wrapping.
  function automatic logic [TOTAL_W-1:0] sat_add(input logic [TOTAL_W-1:0] a,
                                                 input logic [RATE_W-1:0]  b);
    logic [TOTAL_W:0] s;
    s = (TOTAL_W+1)'(a) + (TOTAL_W+1)'(b);
    return s[TOTAL_W] ? '1 : s[TOTAL_W-1:0];
  endfunction

  assign slot_nxt = slot_q + ADDR_W'(1);

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    rate_d       = rate_q;
    rate_valid_d = rate_valid_q;
    pass_d       = pass_q;
    total_d      = total_q;
    sec_cnt_d    = sec_cnt_q;
    mem_d        = mem_q;

    case (state_q)
      IDLE, DONE: begin
        // start takes precedence: a coincident write is dropped
        if (start) begin
          state_d      = RUN;
          slot_d       = '0;
          rate_d       = mem_q[0];
          rate_valid_d = 1'b1;
          pass_d       = '0;
          total_d      = '0;
          sec_cnt_d    = '0;
        end else if (wr_en) begin
          mem_d[wr_addr] = wr_data;
        end
      end
      RUN: begin
        total_d = sat_add(total_q, rate_q);
        if (rate_q >= THRESH_R && sec_cnt_q < WINDOW_S && pass_q < MAX_P)
          pass_d = pass_q + 16'd1;
        if (sec_cnt_q < WINDOW_S)
          sec_cnt_d = sec_cnt_q + SEC_W'(1);

        if (slot_q != LAST_SLOT) begin
          slot_d = slot_nxt;
          rate_d = mem_q[slot_nxt];
        end else if (loop) begin
          slot_d = '0;
          rate_d = mem_q[0];
        end else begin
          state_d      = DONE;
          rate_d       = '0;
          rate_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge secondClk) begin
    if (reset) begin
      state_q      <= IDLE;
      slot_q       <= '0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
      pass_q       <= '0;
      total_q      <= '0;
      sec_cnt_q    <= '0;
      for (int i = 0; i < SLOTS; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      rate_q       <= rate_d;
      rate_valid_q <= rate_valid_d;
      pass_q       <= pass_d;
      total_q      <= total_d;
      sec_cnt_q    <= sec_cnt_d;
      for (int i = 0; i < SLOTS; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign rate          = rate_q;
  assign rate_valid    = rate_valid_q;
  assign slot          = slot_q;
  assign busy          = (state_q == RUN);
  assign done          = (state_q == DONE);
  assign expected_pass = pass_q;
  assign total_steps   = total_q;

endmodule

// File: tb/tb_step_profile_sequencer.sv
// Directed bench for step_profile_sequencer: table-driven single-pass profiles
// plus hand-written sequences for looping, write blocking and mid-run reset.
module tb_step_profile_sequencer;

  logic        secondClk;
  logic        reset;
  logic        start;
  logic        loop;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [8:0]  wr_data;
  logic [8:0]  rate;
  logic        rate_valid;
  logic [3:0]  slot;
  logic        busy;
  logic        done;
  logic [15:0] expected_pass;
  logic [15:0] total_steps;

  int checks;
  int failures;

  step_profile_sequencer dut (
    .secondClk     (secondClk),
    .reset         (reset),
    .start         (start),
    .loop          (loop),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rate          (rate),
    .rate_valid    (rate_valid),
    .slot          (slot),
    .busy          (busy),
    .done          (done),
    .expected_pass (expected_pass),
    .total_steps   (total_steps)
  );

  initial begin
    secondClk = 1'b0;
    forever #5 secondClk = ~secondClk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    int kind;
    int exp_pass;
    int exp_total;
  } vec_t;

  // Profile patterns: 0 all 40, 1 alternating 33/32, 2 ten 10s then 100s,
  // 3 all 0, 4 all 33, 5 all 32, 6 all 511
  function automatic int pat(input int kind, input int i);
    case (kind)
      0: return 40;
      1: return (i % 2 == 0) ? 33 : 32;
      2: return (i < 10) ? 10 : 100;
      3: return 0;
      4: return 33;
      5: return 32;
      default: return 511;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge secondClk);
    @(negedge secondClk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic write_profile(input int kind);
    for (int i = 0; i < 16; i++) begin
      wr_en   = 1'b1;
      wr_addr = 4'(i);
      wr_data = 9'(pat(kind, i));
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " rate"}, int'(rate), 0);
    chk({tag, " rate_valid"}, int'(rate_valid), 0);
    chk({tag, " slot"}, int'(slot), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " expected_pass"}, int'(expected_pass), 0);
    chk({tag, " total_steps"}, int'(total_steps), 0);
  endtask

  vec_t vecs[7];

  initial begin
    int exp_tot;
    int exp_ps;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    loop     = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;

    vecs[0] = '{0, 9, 640};
    vecs[1] = '{1, 5, 520};
    vecs[2] = '{2, 0, 700};
    vecs[3] = '{3, 0, 0};
    vecs[4] = '{4, 9, 528};
    vecs[5] = '{5, 0, 512};
    vecs[6] = '{0, 9, 640};

    tick();
    reset = 1'b0;
    check_reset_state("reset");

    // Single-pass profiles, start held for two edges (second is ignored in RUN)
    for (int v = 0; v < 7; v++) begin
      do_reset();
      write_profile(vecs[v].kind);
      chk("idle busy", int'(busy), 0);
      start = 1'b1;
      tick();
      chk("first rate", int'(rate), pat(vecs[v].kind, 0));
      chk("first slot", int'(slot), 0);
      chk("first valid", int'(rate_valid), 1);
      chk("first busy", int'(busy), 1);
      for (int k = 1; k < 16; k++) begin
        tick();
        if (k == 1) start = 1'b0;
        chk("run slot", int'(slot), k);
        chk("run rate", int'(rate), pat(vecs[v].kind, k));
        chk("run done", int'(done), 0);
      end
      tick();
      chk("end done", int'(done), 1);
      chk("end busy", int'(busy), 0);
      chk("end valid", int'(rate_valid), 0);
      chk("end rate", int'(rate), 0);
      chk("end slot", int'(slot), 15);
      chk("end pass", int'(expected_pass), vecs[v].exp_pass);
      chk("end total", int'(total_steps), vecs[v].exp_total);
      tick();
      chk("hold pass", int'(expected_pass), vecs[v].exp_pass);
      chk("hold total", int'(total_steps), vecs[v].exp_total);
    end

    // Looping at max rate: saturation of total_steps and uninterrupted wrap
    do_reset();
    write_profile(6);
    loop  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 1; j <= 140; j++) begin
      tick();
      exp_tot = (511 * j > 65535) ? 65535 : 511 * j;
      exp_ps  = (j > 9) ? 9 : j;
      chk("loop slot", int'(slot), j % 16);
      chk("loop valid", int'(rate_valid), 1);
      chk("loop total", int'(total_steps), exp_tot);
      chk("loop pass", int'(expected_pass), exp_ps);
    end
    loop = 1'b0;
    for (int j = 0; j < 20 && !done; j++) tick();
    chk("loop end done", int'(done), 1);
    chk("loop end total", int'(total_steps), 65535);
    chk("loop end pass", int'(expected_pass), 9);

    // Writes during RUN are ignored; write coinciding with start is dropped
    do_reset();
    write_profile(0);
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 9'd20;
    tick();
    wr_en = 1'b0;
    loop  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 9'd7;
    tick();
    wr_en = 1'b0;
    chk("wr run slot", int'(slot), 2);
    tick();
    chk("wr run rate pass1", int'(rate), 20);
    for (int j = 0; j < 16; j++) tick();
    chk("wr run slot pass2", int'(slot), 3);
    chk("wr run rate pass2", int'(rate), 20);
    loop = 1'b0;
    for (int j = 0; j < 20 && !done; j++) tick();
    chk("wr done", int'(done), 1);
    start = 1'b1; wr_en = 1'b1; wr_addr = 4'd1; wr_data = 9'd99;
    tick();
    start = 1'b0; wr_en = 1'b0;
    chk("wr+start busy", int'(busy), 1);
    chk("wr+start rate0", int'(rate), 40);
    tick();
    chk("wr+start rate1", int'(rate), 40);

    // Reset mid-run clears everything including the profile
    do_reset();
    write_profile(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 6; j++) tick();
    chk("pre-reset slot", int'(slot), 6);
    do_reset();
    check_reset_state("midrun reset");
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("cleared busy", int'(busy), 1);
    for (int k = 0; k < 16; k++) begin
      chk("cleared rate", int'(rate), 0);
      tick();
    end
    chk("cleared done", int'(done), 1);
    chk("cleared pass", int'(expected_pass), 0);
    chk("cleared total", int'(total_steps), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
